// File: rtl/xosera_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
package xosera_pkg;

  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGEN = 2'd1,
    OWN_HOST = 2'd2,
    OWN_BLIT = 2'd3
  } vram_owner_t;

endpackage

// File: rtl/vram_arb_if.sv
// Requester-side VRAM access port: one pending request at a time, busy/rd_valid handshake.
interface vram_arb_if
  import xosera_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output req, wr, addr, wdata, input busy, rd_valid, rd_data);
  modport slave  (input req, wr, addr, wdata, output busy, rd_valid, rd_data);
endinterface

// File: rtl/vram_arb_port.sv
// One requester port: single-entry pending register, busy flag and read-data capture.
module vram_arb_port
  import xosera_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  vram_arb_if.slave         bus,
  input  logic              grant,
  input  logic              capture,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              pend_valid,
  output logic              pend_wr,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_wdata
);

  logic              valid_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // Requests are only sampled while idle; a request during busy is dropped.
      if (!valid_q) begin
        if (bus.req) begin
          valid_q <= 1'b1;
          wr_q    <= bus.wr;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
        end
      end else if (grant) begin
        valid_q <= 1'b0;
      end
      rd_valid_q <= capture;
      if (capture) begin
        rd_data_q <= vram_rdata;
      end
    end
  end

  assign bus.busy     = valid_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign pend_valid   = valid_q;
  assign pend_wr      = wr_q;
  assign pend_addr    = addr_q;
  assign pend_wdata   = wdata_q;

endmodule

// File: rtl/vram_arb.sv
// VRAM access arbiter: video fetch always wins, host (and blit with VRAM_ARB_BLIT_EN)
// share remaining slots round-robin; read data is routed back via a registered owner tag.
module vram_arb
  import xosera_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vgen_sel,
  input  logic [ADDR_W-1:0] vgen_addr,
  output logic [DATA_W-1:0] vgen_data,
  vram_arb_if.slave         host,
`ifdef VRAM_ARB_BLIT_EN
  vram_arb_if.slave         blit,
`endif
  output logic              vram_sel,
  output logic              vram_wr_en,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  vram_owner_t tag_q, tag_d;

  logic              host_v, host_wr, host_grant;
  logic [ADDR_W-1:0] host_a;
  logic [DATA_W-1:0] host_d;

  vram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_host (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (host),
    .grant      (host_grant),
    .capture    (tag_q == OWN_HOST),
    .vram_rdata (vram_rdata),
    .pend_valid (host_v),
    .pend_wr    (host_wr),
    .pend_addr  (host_a),
    .pend_wdata (host_d)
  );

`ifdef VRAM_ARB_BLIT_EN
  logic              blit_v, blit_wr, blit_grant;
  logic [ADDR_W-1:0] blit_a;
  logic [DATA_W-1:0] blit_d;
  logic              rr_q, rr_d;  // 0: host favoured on contention, 1: blit favoured

  vram_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_blit (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (blit),
    .grant      (blit_grant),
    .capture    (tag_q == OWN_BLIT),
    .vram_rdata (vram_rdata),
    .pend_valid (blit_v),
    .pend_wr    (blit_wr),
    .pend_addr  (blit_a),
    .pend_wdata (blit_d)
  );
`endif

  always_comb begin
    vram_sel   = 1'b0;
    vram_wr_en = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    host_grant = 1'b0;
    tag_d      = OWN_NONE;
`ifdef VRAM_ARB_BLIT_EN
    blit_grant = 1'b0;
    rr_d       = rr_q;
`endif
    if (vgen_sel) begin
      vram_sel  = 1'b1;
      vram_addr = vgen_addr;
      tag_d     = OWN_VGEN;
    end else begin
`ifdef VRAM_ARB_BLIT_EN
      if (host_v && blit_v) begin
        host_grant = !rr_q;
        blit_grant = rr_q;
        rr_d       = !rr_q;
      end else begin
        host_grant = host_v;
        blit_grant = blit_v;
      end
      if (blit_grant) begin
        vram_sel   = 1'b1;
        vram_wr_en = blit_wr;
        vram_addr  = blit_a;
        vram_wdata = blit_d;
        tag_d      = blit_wr ? OWN_NONE : OWN_BLIT;
      end
`else
      host_grant = host_v;
`endif
      if (host_grant) begin
        vram_sel   = 1'b1;
        vram_wr_en = host_wr;
        vram_addr  = host_a;
        vram_wdata = host_d;
        tag_d      = host_wr ? OWN_NONE : OWN_HOST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= OWN_NONE;
`ifdef VRAM_ARB_BLIT_EN
      rr_q  <= 1'b0;
`endif
    end else begin
      tag_q <= tag_d;
`ifdef VRAM_ARB_BLIT_EN
      rr_q  <= rr_d;
`endif
    end
  end

  assign vgen_data = vram_rdata;

endmodule

// File: tb/tb_vram_arb.sv
// Randomized + directed bench for vram_arb against a transaction-level reference model.
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vgen_sel = 1'b0;
  logic [15:0] vgen_addr = '0;
  logic [15:0] vgen_data;
  logic        vram_sel, vram_wr_en;
  logic [15:0] vram_addr, vram_wdata;
  logic [15:0] vram_rdata = '0;

  vram_arb_if #(.ADDR_W(16), .DATA_W(16)) host_if ();
`ifdef VRAM_ARB_BLIT_EN
  vram_arb_if #(.ADDR_W(16), .DATA_W(16)) blit_if ();
`endif

  vram_arb #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vgen_sel   (vgen_sel),
    .vgen_addr  (vgen_addr),
    .vgen_data  (vgen_data),
    .host       (host_if),
`ifdef VRAM_ARB_BLIT_EN
    .blit       (blit_if),
`endif
    .vram_sel   (vram_sel),
    .vram_wr_en (vram_wr_en),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port VRAM with registered read data.
  logic [15:0] vram_mem [65536];
  always @(posedge clk) begin
    if (vram_sel) begin
      if (vram_wr_en) vram_mem[vram_addr] <= vram_wdata;
      else            vram_rdata <= vram_mem[vram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  // Reference model: index 0 = host, 1 = blit.
  logic [15:0] model_mem [65536];
  logic        m_pend [2];
  logic        m_wr [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic        m_stage [2];
  logic [15:0] m_stage_data [2];
  logic        m_vld [2];
  logic [15:0] m_rdata [2];
  int          m_favour;
  logic        m_vgen_due;
  logic [15:0] m_vgen_exp;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0; m_stage[p] = 0; m_vld[p] = 0; m_rdata[p] = '0;
      m_wr[p] = 0; m_addr[p] = '0; m_wdata[p] = '0; m_stage_data[p] = '0;
    end
    m_favour = 0;
    m_vgen_due = 0;
    m_vgen_exp = '0;
  endtask

  // Advance one clock: update the model from pre-edge inputs, then check outputs.
  task automatic step();
    logic        req [2];
    logic        wr [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    logic        pend0 [2];
    int          g;
    @(posedge clk);
    req[0] = host_if.req; wr[0] = host_if.wr; a[0] = host_if.addr; d[0] = host_if.wdata;
`ifdef VRAM_ARB_BLIT_EN
    req[1] = blit_if.req; wr[1] = blit_if.wr; a[1] = blit_if.addr; d[1] = blit_if.wdata;
`else
    req[1] = 0; wr[1] = 0; a[1] = '0; d[1] = '0;
`endif
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        pend0[p] = m_pend[p];
        m_vld[p] = m_stage[p];
        if (m_stage[p]) m_rdata[p] = m_stage_data[p];
        m_stage[p] = 0;
      end
      m_vgen_due = vgen_sel;
      if (vgen_sel) begin
        m_vgen_exp = model_mem[vgen_addr];
      end else begin
        g = -1;
        if (pend0[0] && pend0[1]) begin
          g = m_favour;
          m_favour = 1 - m_favour;
        end else if (pend0[0]) g = 0;
        else if (pend0[1]) g = 1;
        if (g >= 0) begin
          if (m_wr[g]) model_mem[m_addr[g]] = m_wdata[g];
          else begin
            m_stage[g] = 1;
            m_stage_data[g] = model_mem[m_addr[g]];
          end
          m_pend[g] = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend0[p] && req[p]) begin
          m_pend[p] = 1; m_wr[p] = wr[p]; m_addr[p] = a[p]; m_wdata[p] = d[p];
        end
      end
    end
    #1;
    check_eq("host_busy", 32'(host_if.busy), 32'(m_pend[0]));
    check_eq("host_rd_valid", 32'(host_if.rd_valid), 32'(m_vld[0]));
    check_eq("host_rd_data", 32'(host_if.rd_data), 32'(m_rdata[0]));
`ifdef VRAM_ARB_BLIT_EN
    check_eq("blit_busy", 32'(blit_if.busy), 32'(m_pend[1]));
    check_eq("blit_rd_valid", 32'(blit_if.rd_valid), 32'(m_vld[1]));
    check_eq("blit_rd_data", 32'(blit_if.rd_data), 32'(m_rdata[1]));
`endif
    if (m_vgen_due) check_eq("vgen_data", 32'(vgen_data), 32'(m_vgen_exp));
  endtask

  task automatic drive_host(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d);
    host_if.req = r; host_if.wr = w; host_if.addr = a; host_if.wdata = d;
  endtask

`ifdef VRAM_ARB_BLIT_EN
  task automatic drive_blit(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d);
    blit_if.req = r; blit_if.wr = w; blit_if.addr = a; blit_if.wdata = d;
  endtask
`endif

  task automatic check_vram_idle(input string tag);
    check_eq({tag, "_sel"}, 32'(vram_sel), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(vram_wr_en), 32'd0);
    check_eq({tag, "_addr"}, 32'(vram_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(vram_wdata), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram_mem[i] = init_val(i);
      model_mem[i] = init_val(i);
    end
    model_reset();
    drive_host(0, 0, '0, '0);
`ifdef VRAM_ARB_BLIT_EN
    drive_blit(0, 0, '0, '0);
`endif
    step();
    step();
    reset_n = 1'b1;
    check_vram_idle("reset");
    step();

    // Host write then read of 0x0100.
    drive_host(1, 1, 16'h0100, 16'h1234);
    step();
    check_eq("wr_sel", 32'(vram_sel), 32'd1);
    check_eq("wr_en", 32'(vram_wr_en), 32'd1);
    check_eq("wr_addr", 32'(vram_addr), 32'h0100);
    check_eq("wr_wdata", 32'(vram_wdata), 32'h1234);
    drive_host(0, 0, '0, '0);
    step();
    drive_host(1, 0, 16'h0100, '0);
    step();
    check_eq("rd_sel", 32'(vram_sel), 32'd1);
    check_eq("rd_wr_en", 32'(vram_wr_en), 32'd0);
    check_eq("rd_addr", 32'(vram_addr), 32'h0100);
    drive_host(0, 0, '0, '0);
    step();
    check_eq("rd_valid_c2", 32'(host_if.rd_valid), 32'd0);
    step();
    check_eq("rd_valid_c3", 32'(host_if.rd_valid), 32'd1);
    check_eq("rd_data_c3", 32'(host_if.rd_data), 32'h1234);

    // Video holds the slot for 5 cycles while a host read of 0xF000 waits.
    for (int i = 0; i < 5; i++) begin
      vgen_sel = 1'b1;
      vgen_addr = 16'($urandom);
      if (i == 0) drive_host(1, 0, 16'hF000, '0);
      #1;
      check_eq("vgen_owns_addr", 32'(vram_addr), 32'(vgen_addr));
      check_eq("vgen_owns_wr", 32'(vram_wr_en), 32'd0);
      step();
      drive_host(0, 0, '0, '0);
    end
    vgen_sel = 1'b0;
    #1;
    check_eq("starved_grant_sel", 32'(vram_sel), 32'd1);
    check_eq("starved_grant_addr", 32'(vram_addr), 32'hF000);
    step();
    step();
    check_eq("starved_rd_data", 32'(host_if.rd_data), 32'(init_val(16'hF000)));

    // Request during busy is ignored.
    drive_host(1, 1, 16'h0200, 16'hBEEF);
    vgen_sel = 1'b1;
    step();
    drive_host(1, 1, 16'h0300, 16'hDEAD);
    step();
    drive_host(0, 0, '0, '0);
    vgen_sel = 1'b0;
    #1;
    check_eq("busy_ign_addr", 32'(vram_addr), 32'h0200);
    check_eq("busy_ign_wdata", 32'(vram_wdata), 32'hBEEF);
    step();
    check_eq("busy_ign_no_second", 32'(vram_sel), 32'd0);
    step();

    // Reset while a host read is in flight.
    drive_host(1, 0, 16'h0100, '0);
    step();
    drive_host(0, 0, '0, '0);
    step();
    reset_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(host_if.busy), 32'd0);
    check_eq("rst_rd_valid", 32'(host_if.rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(host_if.rd_data), 32'd0);
    check_vram_idle("rst");
    step();
    step();
    reset_n = 1'b1;
    step();
    check_eq("post_rst_no_valid", 32'(host_if.rd_valid), 32'd0);
    drive_host(1, 0, 16'h0100, '0);
    step();
    drive_host(0, 0, '0, '0);
    step();
    step();
    check_eq("post_rst_valid", 32'(host_if.rd_valid), 32'd1);
    check_eq("post_rst_data", 32'(host_if.rd_data), 32'h1234);

    // Back-to-back host requests are granted every other cycle.
    drive_host(1, 0, 16'h0100, '0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("b2b_sel", 32'(vram_sel), 32'((i % 2) == 0));
    end
    drive_host(0, 0, '0, '0);
    repeat (3) step();

`ifdef VRAM_ARB_BLIT_EN
    // Contention alternates: host first, then blit first.
    for (int r = 0; r < 2; r++) begin
      drive_host(1, 0, 16'h0010, '0);
      drive_blit(1, 0, 16'h0020, '0);
      step();
      drive_host(0, 0, '0, '0);
      drive_blit(0, 0, '0, '0);
      check_eq("rr_first", 32'(vram_addr), (r == 0) ? 32'h0010 : 32'h0020);
      step();
      check_eq("rr_second", 32'(vram_addr), (r == 0) ? 32'h0020 : 32'h0010);
      repeat (3) step();
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      vgen_sel = ($urandom_range(0, 1) == 1);
      vgen_addr = 16'($urandom_range(0, 15));
      drive_host(($urandom_range(0, 9) < 6), 1'($urandom), 16'($urandom_range(0, 15)),
                 16'($urandom));
`ifdef VRAM_ARB_BLIT_EN
      drive_blit(($urandom_range(0, 9) < 6), 1'($urandom), 16'($urandom_range(0, 15)),
                 16'($urandom));
`endif
      step();
    end
    vgen_sel = 1'b0;
    drive_host(0, 0, '0, '0);
`ifdef VRAM_ARB_BLIT_EN
    drive_blit(0, 0, '0, '0);
`endif
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
